// File: rtl/atahost_pkg.sv
// Shared definitions for the atahost controller blocks: PIO state encoding
// and the PIO mode-0 timing defaults (phase lengths in cycles minus one).
package atahost_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_EOC    = 3'd4
   } pio_state_e;

   localparam int unsigned PIO_M0_T1   = 6;
   localparam int unsigned PIO_M0_T2   = 28;
   localparam int unsigned PIO_M0_T4   = 2;
   localparam int unsigned PIO_M0_TEOC = 23;

endpackage

// File: rtl/atahost_tcnt.sv
// Loadable phase down-counter with zero flag; load wins over decrement and
// the count saturates at zero so a stalled phase can sit at terminal count.
module atahost_tcnt #(
   parameter int TWIDTH = 8
) (
   input  logic              clk_i,
   input  logic              nreset_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              dec_i,
   input  logic [TWIDTH-1:0] load_val_i,
   output logic [TWIDTH-1:0] cnt_o,
   output logic              zero_o
);

   logic [TWIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - TWIDTH'(1);
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i)
         cnt_q <= '0;
      else if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/atahost_pio_tctrl.sv
// ATA host PIO timing controller: sequences one PIO access with registered strobes.
//   state  | meaning
//   IDLE   | waiting for go
//   SETUP  | address setup (T1), strobes low, oe driven on writes
//   STROBE | DIOR/DIOW active (T2), optionally stretched by IORDY
//   HOLD   | data hold after strobe (T4)
//   EOC    | end-of-cycle recovery (Teoc), bus released
module atahost_pio_tctrl
   import atahost_pkg::*;
#(
   parameter int TWIDTH = 8
) (
   input  logic              clk,
   input  logic              nReset,
   input  logic              rst,
   input  logic              go,
   input  logic              we,
   input  logic [TWIDTH-1:0] T1,
   input  logic [TWIDTH-1:0] T2,
   input  logic [TWIDTH-1:0] T4,
   input  logic [TWIDTH-1:0] Teoc,
   input  logic              IORDYen,
   input  logic              IORDY,
   output logic              busy,
   output logic              DIOR,
   output logic              DIOW,
   output logic              oe,
   output logic              dstrb,
   output logic              done
);

   pio_state_e        state_q, state_d;
   logic              we_q, ien_q;
   logic [TWIDTH-1:0] t2_q, t4_q, teoc_q;
   logic              iordy_s1_q, iordy_s2_q;
   logic              busy_q, dior_q, diow_q, oe_q, dstrb_q, done_q;
   logic              busy_d, dior_d, diow_d, oe_d, dstrb_d, done_d;
   logic              accept, we_n, zero_n;
   logic              cnt_load, cnt_dec, cnt_zero;
   logic [TWIDTH-1:0] cnt_val, cnt_ld_val;

   atahost_tcnt #(.TWIDTH(TWIDTH)) u_tcnt (
      .clk_i      (clk),
      .nreset_i   (nReset),
      .rst_i      (rst),
      .load_i     (cnt_load),
      .dec_i      (cnt_dec),
      .load_val_i (cnt_ld_val),
      .cnt_o      (cnt_val),
      .zero_o     (cnt_zero)
   );

   // done_q marks the cycle after EOC; a go there must not start a new access
   assign accept = (state_q == ST_IDLE) && go && !done_q;
   assign we_n   = accept ? we : we_q;

   always_comb begin
      state_d    = state_q;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      cnt_ld_val = '0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d    = ST_SETUP;
               cnt_load   = 1'b1;
               cnt_ld_val = T1;
            end
         end
         ST_SETUP: begin
            if (cnt_zero) begin
               state_d    = ST_STROBE;
               cnt_load   = 1'b1;
               cnt_ld_val = t2_q;
            end else
               cnt_dec = 1'b1;
         end
         ST_STROBE: begin
            if (cnt_zero) begin
               if (!ien_q || iordy_s2_q) begin
                  state_d    = ST_HOLD;
                  cnt_load   = 1'b1;
                  cnt_ld_val = t4_q;
               end
            end else
               cnt_dec = 1'b1;
         end
         ST_HOLD: begin
            if (cnt_zero) begin
               state_d    = ST_EOC;
               cnt_load   = 1'b1;
               cnt_ld_val = teoc_q;
            end else
               cnt_dec = 1'b1;
         end
         ST_EOC: begin
            if (cnt_zero)
               state_d = ST_IDLE;
            else
               cnt_dec = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Look one cycle ahead so dstrb can be registered: the synchronizer's next
   // output is the current first-stage value.
   always_comb begin
      if (cnt_load)
         zero_n = (cnt_ld_val == '0);
      else if (cnt_dec)
         zero_n = (cnt_val == TWIDTH'(1));
      else
         zero_n = cnt_zero;
      busy_d  = (state_d != ST_IDLE);
      oe_d    = we_n && ((state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                         (state_d == ST_HOLD));
      dior_d  = (state_d == ST_STROBE) && !we_n;
      diow_d  = (state_d == ST_STROBE) && we_n;
      dstrb_d = dior_d && zero_n && (!ien_q || iordy_s1_q);
      done_d  = (state_q == ST_EOC) && cnt_zero;
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         iordy_s1_q <= 1'b0;
         iordy_s2_q <= 1'b0;
      end else if (rst) begin
         iordy_s1_q <= 1'b0;
         iordy_s2_q <= 1'b0;
      end else begin
         iordy_s1_q <= IORDY;
         iordy_s2_q <= iordy_s1_q;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         we_q   <= 1'b0;
         ien_q  <= 1'b0;
         t2_q   <= '0;
         t4_q   <= '0;
         teoc_q <= '0;
      end else if (rst) begin
         we_q   <= 1'b0;
         ien_q  <= 1'b0;
         t2_q   <= '0;
         t4_q   <= '0;
         teoc_q <= '0;
      end else if (accept) begin
         we_q   <= we;
         ien_q  <= IORDYen;
         t2_q   <= T2;
         t4_q   <= T4;
         teoc_q <= Teoc;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         dior_q  <= 1'b0;
         diow_q  <= 1'b0;
         oe_q    <= 1'b0;
         dstrb_q <= 1'b0;
         done_q  <= 1'b0;
      end else if (rst) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         dior_q  <= 1'b0;
         diow_q  <= 1'b0;
         oe_q    <= 1'b0;
         dstrb_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         dior_q  <= dior_d;
         diow_q  <= diow_d;
         oe_q    <= oe_d;
         dstrb_q <= dstrb_d;
         done_q  <= done_d;
      end
   end

   assign busy  = busy_q;
   assign DIOR  = dior_q;
   assign DIOW  = diow_q;
   assign oe    = oe_q;
   assign dstrb = dstrb_q;
   assign done  = done_q;

endmodule

// File: doc/atahost_pio_tctrl.md
ATAHOST_PIO_TCTRL -- requirements
Module: atahost_pio_tctrl

Interface
REQ-001 SHALL have parameter TWIDTH, default 8, meaning width of all timing values and the phase counter.
REQ-002 SHALL have ports clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have nReset  in  1  asynchronous active-low reset.
REQ-004 SHALL have rst  in  1  synchronous active-high reset.
REQ-005 SHALL have go  in  1  one-cycle request to start one PIO access.
REQ-006 SHALL have we  in  1  access direction, 1 = write, 0 = read, sampled with go.
REQ-007 SHALL have T1, T2, T4, Teoc  in  TWIDTH each  phase lengths in cycles minus one, sampled with go.
REQ-008 SHALL have IORDYen  in  1  enables IORDY wait-state extension, sampled with go.
REQ-009 SHALL have IORDY  in  1  asynchronous device ready line.
REQ-010 SHALL have busy  out  1  high from first cycle after go accepted until access ends.
REQ-011 SHALL have DIOR, DIOW  out  1 each  registered active-high strobes, inverted by the parent to DIORn/DIOWn.
REQ-012 SHALL have oe  out  1  registered data-bus output enable.
REQ-013 SHALL have dstrb  out  1  one-cycle read-data capture pulse.
REQ-014 SHALL have done  out  1  one-cycle access-complete pulse.

Function
REQ-015 SHALL implement states IDLE, SETUP, STROBE, HOLD, EOC.
REQ-016 SHALL accept go only in IDLE; go in any other state SHALL be ignored.
REQ-017 On accepted go, SHALL latch we, T1, T2, T4, Teoc and IORDYen, load the counter with T1 and enter SETUP.
REQ-018 In every phase, the counter SHALL decrement by 1 each cycle; the phase SHALL end on the cycle the counter equals 0, so a phase lasts value+1 cycles (value 0 gives 1 cycle).
REQ-019 In SETUP, DIOR=DIOW=0 and oe=latched we; at end, SHALL load T2 and enter STROBE.
REQ-020 In STROBE, DIOW=latched we and DIOR=not latched we; oe=latched we.
REQ-021 IORDY SHALL pass through a two-flop synchronizer; when latched IORDYen=1, the counter is 0 and synchronized IORDY=0, STROBE SHALL hold with the counter at 0 until synchronized IORDY=1.
REQ-022 When STROBE ends on a read, dstrb SHALL pulse for exactly the last STROBE cycle; dstrb SHALL stay 0 on writes.
REQ-023 At end of STROBE, SHALL load T4 and enter HOLD; DIOR=DIOW=0 and oe=latched we.
REQ-024 At end of HOLD, SHALL load Teoc and enter EOC; DIOR=DIOW=oe=0.
REQ-025 At end of EOC, SHALL pulse done for one cycle and return to IDLE; a go sampled in that same cycle SHALL be ignored.
REQ-026 SHALL hold busy=1 in every state except IDLE.
REQ-027 SHALL never assert DIOR and DIOW in the same cycle.
REQ-028 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-029 nReset low SHALL asynchronously force IDLE, counter 0, synchronizer flops 0, and busy=DIOR=DIOW=oe=dstrb=done=0.
REQ-030 rst high SHALL produce the same state on the next edge, including mid-access; an aborted access SHALL emit neither done nor dstrb.

Structure
REQ-031 State encoding and the PIO mode-0 defaults (T1=6, T2=28, T4=2, Teoc=23) SHALL live in a shared atahost package/include used by all atahost blocks.
REQ-032 The loadable down-counter with zero flag SHALL be one sub-module, atahost_tcnt, parameterized by TWIDTH.

Verification
REQ-033 Write with mode-0 defaults and IORDYen=0 -> busy for 7+29+3+24=63 cycles; DIOW high for exactly 29 cycles, starting 7 cycles after busy rises; oe high 39 cycles; done once; dstrb never.
REQ-034 Read with T1=T2=T4=Teoc=0 -> DIOR high 1 cycle; dstrb coincides with it; oe never high; done 4 cycles after busy rises.
REQ-035 Read with IORDYen=1, IORDY low for 40 cycles -> STROBE extends until 2 cycles after IORDY rises; dstrb on the final DIOR cycle.
REQ-036 go pulses during STROBE and during the done cycle -> ignored; exactly one access observed.
REQ-037 nReset asserted mid-STROBE, then rst asserted mid-HOLD on a new access -> all outputs 0 immediately, or on the next edge for rst; no done or dstrb; next go starts a clean access.
REQ-038 Write with IORDYen=0 while IORDY is held low -> timing identical to REQ-033.
